t5_lsu: RTL and testbench

- Load/store unit of the t5 RV32I core; the memory-side consumer of the execute stage outputs.
- Takes the registered opcode, funct3, effective address and replicated store data from execute.
- Runs one request/acknowledge transaction on the data bus per load/store.
- Returns aligned, sign- or zero-extended load data, and holds the pipeline stalled while a transaction is outstanding.

---
 rtl/t5_lsu_pkg.sv | 33 +++
 rtl/t5_lsu_if.sv | 27 ++
 rtl/t5_lsu_align.sv | 33 +++
 rtl/t5_lsu.sv | 136 +++++++++++++
 tb/tb_t5_lsu.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/t5_lsu_pkg.sv
// t5_pkg: shared constants for the t5 load/store unit.
//   - opcode[6:2] values for loads and stores
//   - funct3 access-size encodings
//   - LSU FSM state type
//   - lane_sel(): byte-lane mask for a given funct3 and address offset
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_REQ  = 1'b1
  } lsu_state_e;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic [3:0] lane_sel(input logic [2:0] fn3, input logic [1:0] off);
    logic [3:0] sel;
    case (fn3[1:0])
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = 4'b0011 << {off[1], 1'b0};
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/t5_lsu_if.sv
// t5_lsu_if: request/acknowledge data bus between the LSU and memory.
//   dstb  request valid          dwre  1=write, 0=read
//   dsel  byte lane selects      dadr  word address
//   dwdt  write data             dack  acknowledge (one cycle)
//   drdt  read data, valid with dack
// master = LSU side, slave = memory side.
interface t5_lsu_if #(
  parameter int XLEN = 32
);
  logic            dstb;
  logic            dwre;
  logic [3:0]      dsel;
  logic [XLEN-3:0] dadr;
  logic [XLEN-1:0] dwdt;
  logic            dack;
  logic [XLEN-1:0] drdt;

  modport master (
    output dstb, dwre, dsel, dadr, dwdt,
    input  dack, drdt
  );

  modport slave (
    input  dstb, dwre, dsel, dadr, dwdt,
    output dack, drdt
  );
endinterface

// File: rtl/t5_lsu_align.sv
// t5_lsu_align: combinational load-data aligner.
//   drdt_i  raw bus read word
//   off_i   byte offset of the access (address bits [1:0])
//   fn3_i   load funct3 (LB/LH/LW/LBU/LHU)
//   res_o   lane-selected, sign- or zero-extended result
module t5_lsu_align
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] drdt_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      fn3_i,
  output logic [XLEN-1:0] res_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = drdt_i[{off_i, 3'b000} +: 8];
    half_v = drdt_i[{off_i[1], 4'b0000} +: 16];
    res_o  = drdt_i;
    case (fn3_i)
      F3_B:    res_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   res_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    res_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   res_o = {{(XLEN-16){1'b0}}, half_v};
      default: res_o = drdt_i;
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// t5_lsu: load/store unit of the t5 RV32I core.
//   sclk, srst        clock (rising edge), async active-low reset
//   sena              pipeline enable; requests accepted only when high
//   xopc, xfn3        opcode[6:2] and funct3 from execute
//   xbpc, xdat        effective address and lane-replicated store data
//   dbus              data bus (t5_lsu_if master)
//   mdat, mvld        aligned load result and its one-cycle update pulse
//   merr              one-cycle pulse: misaligned, illegal funct3 or bus timeout
//   mstall            stall request while a bus transaction is outstanding
module t5_lsu
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TMOW = 8,
  parameter int TMO  = 255
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xbpc,
  input  logic [XLEN-1:0] xdat,
  t5_lsu_if.master        dbus,
  output logic [XLEN-1:0] mdat,
  output logic            mvld,
  output logic            merr,
  output logic            mstall
);

  lsu_state_e      state_q;
  logic            dwre_q;
  logic [3:0]      dsel_q;
  logic [XLEN-3:0] dadr_q;
  logic [XLEN-1:0] dwdt_q;
  logic [1:0]      off_q;
  logic [2:0]      fn3_q;
  logic [TMOW-1:0] wdog_q;
  logic [XLEN-1:0] mdat_q;
  logic            mvld_q;
  logic            merr_q;

  logic            is_load;
  logic            is_store;
  logic            fn_ok;
  logic            align_ok;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    is_load  = (xopc == OPC_LOAD);
    is_store = (xopc == OPC_STORE);
    fn_ok    = 1'b0;
    if (is_load)
      fn_ok = (xfn3 == F3_B) || (xfn3 == F3_H) || (xfn3 == F3_W) ||
              (xfn3 == F3_BU) || (xfn3 == F3_HU);
    else if (is_store)
      fn_ok = (xfn3 == F3_B) || (xfn3 == F3_H) || (xfn3 == F3_W);
    case (xfn3[1:0])
      2'b01:   align_ok = ~xbpc[0];
      2'b10:   align_ok = (xbpc[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  // Alignment works from the registered offset/funct3 so it stays valid while
  // execute moves on during the bus transaction.
  t5_lsu_align #(.XLEN(XLEN)) u_align (
    .drdt_i (dbus.drdt),
    .off_i  (off_q),
    .fn3_i  (fn3_q),
    .res_o  (ld_data)
  );

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= LSU_IDLE;
      dwre_q  <= 1'b0;
      dsel_q  <= '0;
      dadr_q  <= '0;
      dwdt_q  <= '0;
      off_q   <= '0;
      fn3_q   <= '0;
      wdog_q  <= '0;
      mdat_q  <= '0;
      mvld_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      mvld_q <= 1'b0;
      merr_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (sena && (is_load || is_store)) begin
            if (fn_ok && align_ok) begin
              dadr_q  <= xbpc[XLEN-1:2];
              dwre_q  <= is_store;
              dwdt_q  <= xdat;
              dsel_q  <= lane_sel(xfn3, xbpc[1:0]);
              off_q   <= xbpc[1:0];
              fn3_q   <= xfn3;
              wdog_q  <= '0;
              state_q <= LSU_REQ;
            end else begin
              merr_q <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          // dack is checked before the watchdog so a late ack still completes.
          if (dbus.dack) begin
            state_q <= LSU_IDLE;
            if (!dwre_q) begin
              mdat_q <= ld_data;
              mvld_q <= 1'b1;
            end
          end else if (wdog_q == TMOW'(TMO - 1)) begin
            state_q <= LSU_IDLE;
            merr_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + TMOW'(1);
          end
        end
      endcase
    end
  end

  assign dbus.dstb = (state_q == LSU_REQ);
  assign dbus.dwre = dwre_q;
  assign dbus.dsel = dsel_q;
  assign dbus.dadr = dadr_q;
  assign dbus.dwdt = dwdt_q;
  assign mstall    = (state_q == LSU_REQ);
  assign mdat      = mdat_q;
  assign mvld      = mvld_q;
  assign merr      = merr_q;

endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: self-checking bench for t5_lsu. Directed cases followed by
// randomized loads/stores with random ack latency, compared against a
// behavioural model of the access rules.
module tb_t5_lsu;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic        sclk = 1'b0;
  logic        srst;
  logic        sena;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xbpc;
  logic [31:0] xdat;
  logic [31:0] mdat;
  logic        mvld;
  logic        merr;
  logic        mstall;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_mdat = '0;

  t5_lsu_if #(.XLEN(XLEN)) dbus ();

  t5_lsu #(.XLEN(XLEN), .TMOW(8), .TMO(TMO)) dut (
    .sclk   (sclk),
    .srst   (srst),
    .sena   (sena),
    .xopc   (xopc),
    .xfn3   (xfn3),
    .xbpc   (xbpc),
    .xdat   (xdat),
    .dbus   (dbus),
    .mdat   (mdat),
    .mvld   (mvld),
    .merr   (merr),
    .mstall (mstall)
  );

  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_dstb"},   32'(dbus.dstb), 32'd0);
    chk({tag, "_mstall"}, 32'(mstall),    32'd0);
    chk({tag, "_mvld"},   32'(mvld),      32'd0);
    chk({tag, "_merr"},   32'(merr),      32'd0);
    chk({tag, "_mdat"},   mdat,           exp_mdat);
  endtask

  // Idle cycles with random stray dack pulses, which must be ignored.
  task automatic gap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      dbus.dack = 1'($urandom);
      dbus.drdt = $urandom;
      tick();
      dbus.dack = 1'b0;
      idle_chk("gap");
    end
  endtask

  // One operation presented for a single cycle. lat = REQ cycle in which dack
  // is raised (1 = zero-wait); lat > TMO means the bus never answers.
  task automatic do_op(input logic [4:0] opc, input logic [2:0] fn3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned lat, input logic [31:0] rdata);
    bit          is_ld, is_st, legal;
    int unsigned nb, off;
    logic [3:0]  esel;
    logic [31:0] sh, res;
    is_ld = (opc == 5'h00);
    is_st = (opc == 5'h08);
    case (fn3[1:0])
      2'd0: nb = 1;
      2'd1: nb = 2;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    off   = addr % 4;
    legal = (is_ld && fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
            (is_st && fn3 inside {3'd0, 3'd1, 3'd2});
    if (legal) legal = (addr % nb) == 0;

    sena = 1'b1; xopc = opc; xfn3 = fn3; xbpc = addr; xdat = wdata;
    tick();
    sena = 1'b0; xopc = 5'($urandom); xfn3 = 3'($urandom);
    xbpc = $urandom; xdat = $urandom;

    if (!is_ld && !is_st) begin
      idle_chk("nonmem");
      return;
    end
    if (!legal) begin
      chk("bad_merr",  32'(merr),      32'd1);
      chk("bad_dstb",  32'(dbus.dstb), 32'd0);
      chk("bad_stall", 32'(mstall),    32'd0);
      chk("bad_mdat",  mdat,           exp_mdat);
      tick();
      chk("bad_merr_pulse", 32'(merr), 32'd0);
      return;
    end

    esel = 4'(((1 << nb) - 1) << off);
    for (int cyc = 1; cyc <= TMO; cyc++) begin
      chk("req_dstb",  32'(dbus.dstb), 32'd1);
      chk("req_stall", 32'(mstall),    32'd1);
      chk("req_dadr",  32'(dbus.dadr), addr >> 2);
      chk("req_dsel",  32'(dbus.dsel), 32'(esel));
      chk("req_dwre",  32'(dbus.dwre), 32'(is_st));
      chk("req_dwdt",  dbus.dwdt,      wdata);
      chk("req_mvld",  32'(mvld),      32'd0);
      chk("req_merr",  32'(merr),      32'd0);
      if (cyc == lat) begin
        dbus.dack = 1'b1;
        dbus.drdt = rdata;
      end
      tick();
      dbus.dack = 1'b0;
      dbus.drdt = $urandom;
      if (cyc == lat) begin
        if (is_ld) begin
          sh = rdata >> (8 * off);
          if (nb == 1) begin
            res = sh & 32'hFF;
            if (fn3 < 4 && res >= 32'h80) res = res | 32'hFFFF_FF00;
          end else if (nb == 2) begin
            res = sh & 32'hFFFF;
            if (fn3 < 4 && res >= 32'h8000) res = res | 32'hFFFF_0000;
          end else begin
            res = rdata;
          end
          exp_mdat = res;
        end
        chk("ack_mvld",  32'(mvld),      32'(is_ld));
        chk("ack_merr",  32'(merr),      32'd0);
        chk("ack_dstb",  32'(dbus.dstb), 32'd0);
        chk("ack_stall", 32'(mstall),    32'd0);
        chk("ack_mdat",  mdat,           exp_mdat);
        break;
      end
      if (cyc == TMO) begin
        chk("tmo_merr", 32'(merr),      32'd1);
        chk("tmo_mvld", 32'(mvld),      32'd0);
        chk("tmo_dstb", 32'(dbus.dstb), 32'd0);
        chk("tmo_mdat", mdat,           exp_mdat);
      end
    end
  endtask

  initial begin
    int unsigned r;
    logic [4:0]  ropc;
    srst = 1'b0; sena = 1'b0; xopc = '0; xfn3 = '0; xbpc = '0; xdat = '0;
    dbus.dack = 1'b0; dbus.drdt = '0;
    tick();
    tick();
    chk("rst_dstb", 32'(dbus.dstb), 32'd0);
    chk("rst_dwre", 32'(dbus.dwre), 32'd0);
    chk("rst_dsel", 32'(dbus.dsel), 32'd0);
    chk("rst_dadr", 32'(dbus.dadr), 32'd0);
    chk("rst_dwdt", dbus.dwdt,      32'd0);
    idle_chk("rst");
    @(negedge sclk);
    srst = 1'b1;
    tick();

    // Directed cases
    do_op(5'h00, 3'b010, 32'h0000_1004, 32'h5555_AAAA, 4, 32'hDEAD_BEEF);
    chk("lw_value", mdat, 32'hDEAD_BEEF);
    gap(1);
    do_op(5'h00, 3'b000, 32'h0000_1007, 32'h0, 2, 32'h80FF_0000);
    chk("lb_value", mdat, 32'hFFFF_FF80);
    do_op(5'h00, 3'b100, 32'h0000_1007, 32'h0, 1, 32'h80FF_0000);
    chk("lbu_value", mdat, 32'h0000_0080);
    do_op(5'h08, 3'b001, 32'h0000_2002, 32'h1234_1234, 1, 32'h0);
    do_op(5'h00, 3'b010, 32'h0000_1002, 32'h0, 1, 32'h0);
    do_op(5'h00, 3'b110, 32'h0000_1000, 32'h0, 1, 32'h0);
    do_op(5'h08, 3'b100, 32'h0000_1000, 32'h0, 1, 32'h0);
    do_op(5'h00, 3'b010, 32'h0000_3000, 32'h0, TMO + 1, 32'h0);
    do_op(5'h00, 3'b101, 32'h0000_3002, 32'h0, TMO, 32'h8001_7FFF);
    do_op(5'h04, 3'b010, 32'h0000_3000, 32'h0, 1, 32'h0);

    // Reset asserted mid-transaction
    sena = 1'b1; xopc = 5'h00; xfn3 = 3'b010; xbpc = 32'h0000_4000; xdat = '0;
    tick();
    sena = 1'b0;
    tick();
    chk("mid_dstb_before", 32'(dbus.dstb), 32'd1);
    srst = 1'b0;
    #1;
    chk("mid_rst_dstb",  32'(dbus.dstb), 32'd0);
    chk("mid_rst_stall", 32'(mstall),    32'd0);
    chk("mid_rst_mdat",  mdat,           32'd0);
    exp_mdat = '0;
    @(negedge sclk);
    srst = 1'b1;
    tick();
    do_op(5'h00, 3'b010, 32'h0000_4008, 32'h0, 2, 32'h0BAD_F00D);

    // Randomized traffic, including back-to-back ops (gap of 0)
    for (int unsigned n = 0; n < 200; n++) begin
      r = $urandom % 8;
      if (r < 3)      ropc = 5'h00;
      else if (r < 7) ropc = 5'h08;
      else            ropc = 5'($urandom);
      do_op(ropc, 3'($urandom), $urandom, $urandom,
            $urandom_range(TMO + 2, 1), $urandom);
      gap($urandom % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
